// File: rtl/wb_stage.sv
// Writeback stage: commits GPR, EFLAGS, ECX and EIP/CS state in order, and
// issues data-cache stores with a req/ack handshake that stalls the pipeline.
module wb_stage #(
  parameter logic [31:0] FLAGS_RESET = 32'h0000_0002
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WB_V,
  input  logic [31:0] WB_NEIP,
  input  logic [15:0] WB_NCS,
  input  logic [1:0]  WB_de_datasize_all,
  input  logic        WB_de_ld_gpr1_wb,
  input  logic        WB_de_dcache_write_wb,
  input  logic [6:0]  WB_de_flags_affected_wb,
  input  logic        WB_de_rep_wb,
  input  logic        WB_de_repne_wb,
  input  logic [31:0] WB_ALU32_RESULT,
  input  logic [31:0] WB_FLAGS,
  input  logic [31:0] WB_COUNT,
  input  logic [31:0] WB_ADDRESS,
  input  logic [2:0]  WB_DR1,
  input  logic        dc_wr_ack,
  output logic        gpr_wr_en,
  output logic [2:0]  gpr_wr_sel,
  output logic [31:0] gpr_wr_data,
  output logic [1:0]  gpr_wr_size,
  output logic        ecx_wr_en,
  output logic [31:0] ecx_wr_data,
  output logic        dc_wr_req,
  output logic [31:0] dc_wr_addr,
  output logic [31:0] dc_wr_data,
  output logic [1:0]  dc_wr_size,
  output logic        eip_wr_en,
  output logic [31:0] eip_out,
  output logic [15:0] cs_out,
  output logic        rep_repeat,
  output logic [31:0] eflags,
  output logic        wb_stall,
  output logic [31:0] retired_cnt
);

  localparam logic [0:0] S_IDLE       = 1'b0;
  localparam logic [0:0] S_STORE_WAIT = 1'b1;

  logic [0:0]  state, state_nxt;
  logic [31:0] held_addr, held_data;
  logic [1:0]  held_size;

  logic        rep_active, rep_skip, store_needed, commit, flag_wr, zf_new;
  logic [31:0] count_dec, flag_mask, flags_merged, sized_result;

  // The 7-bit affected mask is packed {OF,DF,SF,ZF,AF,PF,CF}; scatter it to
  // the architectural EFLAGS bit positions.
  function automatic logic [31:0] expand_mask(input logic [6:0] m);
    logic [31:0] r;
    r     = '0;
    r[11] = m[6];
    r[10] = m[5];
    r[7]  = m[4];
    r[6]  = m[3];
    r[4]  = m[2];
    r[2]  = m[1];
    r[0]  = m[0];
    return r;
  endfunction

  // Size code 3 is treated as 32-bit.
  function automatic logic [31:0] size_mask(input logic [31:0] v, input logic [1:0] sz);
    logic [31:0] r;
    case (sz)
      2'd0:    r = {24'h0, v[7:0]};
      2'd1:    r = {16'h0, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign rep_active   = WB_de_rep_wb | WB_de_repne_wb;
  assign rep_skip     = rep_active && (WB_COUNT == 32'd0);
  assign count_dec    = WB_COUNT - 32'd1;
  assign store_needed = WB_de_dcache_write_wb && !rep_skip;
  assign flag_mask    = expand_mask(WB_de_flags_affected_wb);
  assign flags_merged = (eflags & ~flag_mask) | (WB_FLAGS & flag_mask);
  assign zf_new       = flags_merged[6];
  assign sized_result = size_mask(WB_ALU32_RESULT, WB_de_datasize_all);

  assign gpr_wr_sel   = WB_DR1;
  assign gpr_wr_data  = sized_result;
  assign gpr_wr_size  = WB_de_datasize_all;
  assign ecx_wr_data  = count_dec;
  assign eip_out      = WB_NEIP;
  assign cs_out       = WB_NCS;

  // While waiting, the request is driven from the captured copy so the
  // dcache sees a stable transaction regardless of upstream behaviour.
  assign dc_wr_addr = (state == S_STORE_WAIT) ? held_addr : WB_ADDRESS;
  assign dc_wr_data = (state == S_STORE_WAIT) ? held_data : sized_result;
  assign dc_wr_size = (state == S_STORE_WAIT) ? held_size : WB_de_datasize_all;

  // NOTE: every signal driven here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    commit     = 1'b0;
    dc_wr_req  = 1'b0;
    wb_stall   = 1'b0;
    gpr_wr_en  = 1'b0;
    ecx_wr_en  = 1'b0;
    flag_wr    = 1'b0;
    rep_repeat = 1'b0;
    eip_wr_en  = 1'b0;

    // Reset is asynchronous, so the combinational enables are gated by it too.
    if (RST) begin
      case (state)
        S_IDLE: begin
          if (WB_V) begin
            if (store_needed) begin
              dc_wr_req = 1'b1;
              if (dc_wr_ack) begin
                commit = 1'b1;
              end else begin
                wb_stall  = 1'b1;
                state_nxt = S_STORE_WAIT;
              end
            end else begin
              commit = 1'b1;
            end
          end
        end
        S_STORE_WAIT: begin
          dc_wr_req = 1'b1;
          if (dc_wr_ack) begin
            commit    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            wb_stall = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    if (commit) begin
      gpr_wr_en  = WB_de_ld_gpr1_wb && !rep_skip;
      flag_wr    = !rep_skip;
      ecx_wr_en  = rep_active && !rep_skip;
      rep_repeat = rep_active && !rep_skip && (count_dec != 32'd0) &&
                   !(WB_de_repne_wb && zf_new);
      eip_wr_en  = !rep_repeat;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      eflags      <= FLAGS_RESET;
      retired_cnt <= 32'd0;
      held_addr   <= 32'd0;
      held_data   <= 32'd0;
      held_size   <= 2'd0;
    end else begin
      state <= state_nxt;
      if (flag_wr) begin
        eflags <= flags_merged;
      end
      if (eip_wr_en) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
      if (state == S_IDLE && wb_stall) begin
        held_addr <= WB_ADDRESS;
        held_data <= sized_result;
        held_size <= WB_de_datasize_all;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: hand-computed vectors covering ALU commit,
// stores with and without wait, REP/REPNE handling, reset mid-store and wrap.
module tb_wb_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WB_V;
  logic [31:0] WB_NEIP;
  logic [15:0] WB_NCS;
  logic [1:0]  WB_de_datasize_all;
  logic        WB_de_ld_gpr1_wb;
  logic        WB_de_dcache_write_wb;
  logic [6:0]  WB_de_flags_affected_wb;
  logic        WB_de_rep_wb;
  logic        WB_de_repne_wb;
  logic [31:0] WB_ALU32_RESULT;
  logic [31:0] WB_FLAGS;
  logic [31:0] WB_COUNT;
  logic [31:0] WB_ADDRESS;
  logic [2:0]  WB_DR1;
  logic        dc_wr_ack;
  logic        gpr_wr_en;
  logic [2:0]  gpr_wr_sel;
  logic [31:0] gpr_wr_data;
  logic [1:0]  gpr_wr_size;
  logic        ecx_wr_en;
  logic [31:0] ecx_wr_data;
  logic        dc_wr_req;
  logic [31:0] dc_wr_addr;
  logic [31:0] dc_wr_data;
  logic [1:0]  dc_wr_size;
  logic        eip_wr_en;
  logic [31:0] eip_out;
  logic [15:0] cs_out;
  logic        rep_repeat;
  logic [31:0] eflags;
  logic        wb_stall;
  logic [31:0] retired_cnt;

  int tests  = 0;
  int failed = 0;

  wb_stage dut (
    .CLK(CLK), .RST(RST), .WB_V(WB_V), .WB_NEIP(WB_NEIP), .WB_NCS(WB_NCS),
    .WB_de_datasize_all(WB_de_datasize_all),
    .WB_de_ld_gpr1_wb(WB_de_ld_gpr1_wb),
    .WB_de_dcache_write_wb(WB_de_dcache_write_wb),
    .WB_de_flags_affected_wb(WB_de_flags_affected_wb),
    .WB_de_rep_wb(WB_de_rep_wb), .WB_de_repne_wb(WB_de_repne_wb),
    .WB_ALU32_RESULT(WB_ALU32_RESULT), .WB_FLAGS(WB_FLAGS),
    .WB_COUNT(WB_COUNT), .WB_ADDRESS(WB_ADDRESS), .WB_DR1(WB_DR1),
    .dc_wr_ack(dc_wr_ack),
    .gpr_wr_en(gpr_wr_en), .gpr_wr_sel(gpr_wr_sel),
    .gpr_wr_data(gpr_wr_data), .gpr_wr_size(gpr_wr_size),
    .ecx_wr_en(ecx_wr_en), .ecx_wr_data(ecx_wr_data),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr),
    .dc_wr_data(dc_wr_data), .dc_wr_size(dc_wr_size),
    .eip_wr_en(eip_wr_en), .eip_out(eip_out), .cs_out(cs_out),
    .rep_repeat(rep_repeat), .eflags(eflags), .wb_stall(wb_stall),
    .retired_cnt(retired_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    WB_V = 0; WB_NEIP = 32'h0; WB_NCS = 16'h0; WB_de_datasize_all = 2'd2;
    WB_de_ld_gpr1_wb = 0; WB_de_dcache_write_wb = 0; WB_de_flags_affected_wb = 7'h0;
    WB_de_rep_wb = 0; WB_de_repne_wb = 0; WB_ALU32_RESULT = 32'h0; WB_FLAGS = 32'h0;
    WB_COUNT = 32'h0; WB_ADDRESS = 32'h0; WB_DR1 = 3'd0; dc_wr_ack = 0;
  endtask

  // Inputs change on the falling edge; outputs are sampled mid-low-phase
  // (combinational) and 1ns after the rising edge (registered).
  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  initial begin
    idle_inputs();
    RST = 0;
    #12;
    check("rst_eflags", eflags, 32'h0000_0002);
    check("rst_retired", retired_cnt, 32'd0);
    check("rst_req", {31'd0, dc_wr_req}, 32'd0);
    @(negedge CLK); RST = 1;

    // ALU op, 16-bit result to GPR 3, mask ZF|CF
    @(negedge CLK);
    WB_V = 1; WB_ALU32_RESULT = 32'h1234_5678; WB_de_datasize_all = 2'd1;
    WB_de_ld_gpr1_wb = 1; WB_DR1 = 3'd3; WB_de_flags_affected_wb = 7'b0001001;
    WB_FLAGS = 32'h41; WB_NEIP = 32'h0000_0100; WB_NCS = 16'h0008;
    settle();
    check("alu_gpr_en", {31'd0, gpr_wr_en}, 32'd1);
    check("alu_gpr_data", gpr_wr_data, 32'h0000_5678);
    check("alu_gpr_sel", {29'd0, gpr_wr_sel}, 32'd3);
    check("alu_gpr_size", {30'd0, gpr_wr_size}, 32'd1);
    check("alu_eip_en", {31'd0, eip_wr_en}, 32'd1);
    check("alu_eip", eip_out, 32'h0000_0100);
    check("alu_cs", {16'd0, cs_out}, 32'h0000_0008);
    check("alu_req", {31'd0, dc_wr_req}, 32'd0);
    check("alu_eflags_old", eflags, 32'h0000_0002);
    tick();
    check("alu_eflags", eflags, 32'h0000_0043);
    check("alu_retired", retired_cnt, 32'd1);

    // Store, ack on the 4th cycle; result masked to 8 bits
    @(negedge CLK);
    idle_inputs();
    WB_V = 1; WB_de_dcache_write_wb = 1; WB_ADDRESS = 32'h0000_1000;
    WB_ALU32_RESULT = 32'hFFFF_FFAB; WB_de_datasize_all = 2'd0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      if (cyc > 1) @(negedge CLK);
      dc_wr_ack = (cyc == 4);
      settle();
      check($sformatf("st_req_c%0d", cyc), {31'd0, dc_wr_req}, 32'd1);
      check($sformatf("st_stall_c%0d", cyc), {31'd0, wb_stall}, {31'd0, cyc != 4});
      check($sformatf("st_eip_c%0d", cyc), {31'd0, eip_wr_en}, {31'd0, cyc == 4});
      check($sformatf("st_addr_c%0d", cyc), dc_wr_addr, 32'h0000_1000);
      check($sformatf("st_data_c%0d", cyc), dc_wr_data, 32'h0000_00AB);
      check($sformatf("st_size_c%0d", cyc), {30'd0, dc_wr_size}, 32'd0);
      tick();
      check($sformatf("st_retired_c%0d", cyc), retired_cnt, (cyc == 4) ? 32'd2 : 32'd1);
    end
    @(negedge CLK);
    idle_inputs();
    settle();
    check("st_idle_req", {31'd0, dc_wr_req}, 32'd0);
    check("st_idle_stall", {31'd0, wb_stall}, 32'd0);

    // Store acked in the same cycle: no stall
    WB_V = 1; WB_de_dcache_write_wb = 1; WB_ADDRESS = 32'h0000_2000;
    WB_ALU32_RESULT = 32'hCAFE_BABE; WB_de_datasize_all = 2'd2; dc_wr_ack = 1;
    settle();
    check("st0_req", {31'd0, dc_wr_req}, 32'd1);
    check("st0_stall", {31'd0, wb_stall}, 32'd0);
    check("st0_data", dc_wr_data, 32'hCAFE_BABE);
    check("st0_eip", {31'd0, eip_wr_en}, 32'd1);
    tick();
    check("st0_retired", retired_cnt, 32'd3);

    // REPNE, COUNT=5, ZF becomes 1: terminates
    @(negedge CLK);
    idle_inputs();
    WB_V = 1; WB_de_rep_wb = 1; WB_de_repne_wb = 1; WB_COUNT = 32'd5;
    WB_de_flags_affected_wb = 7'b0001000; WB_FLAGS = 32'h40;
    settle();
    check("repne_z1_ecx_en", {31'd0, ecx_wr_en}, 32'd1);
    check("repne_z1_ecx", ecx_wr_data, 32'd4);
    check("repne_z1_repeat", {31'd0, rep_repeat}, 32'd0);
    check("repne_z1_eip", {31'd0, eip_wr_en}, 32'd1);
    tick();
    check("repne_z1_retired", retired_cnt, 32'd4);

    // REPNE, ZF=0: repeats, no retire
    @(negedge CLK);
    WB_FLAGS = 32'h0;
    settle();
    check("repne_z0_repeat", {31'd0, rep_repeat}, 32'd1);
    check("repne_z0_eip", {31'd0, eip_wr_en}, 32'd0);
    tick();
    check("repne_z0_eflags", eflags, 32'h0000_0003);
    check("repne_z0_retired", retired_cnt, 32'd4);

    // Plain REP ignores ZF
    @(negedge CLK);
    WB_de_repne_wb = 0; WB_FLAGS = 32'h40;
    settle();
    check("rep_z1_repeat", {31'd0, rep_repeat}, 32'd1);
    tick();
    check("rep_z1_eflags", eflags, 32'h0000_0043);
    check("rep_z1_retired", retired_cnt, 32'd4);

    // REP, COUNT=0: nothing written, instruction retires
    @(negedge CLK);
    idle_inputs();
    WB_V = 1; WB_de_rep_wb = 1; WB_COUNT = 32'd0; WB_de_dcache_write_wb = 1;
    WB_de_ld_gpr1_wb = 1; WB_de_flags_affected_wb = 7'h7F; WB_FLAGS = 32'hFFFF_FFFF;
    settle();
    check("rep0_gpr", {31'd0, gpr_wr_en}, 32'd0);
    check("rep0_ecx", {31'd0, ecx_wr_en}, 32'd0);
    check("rep0_req", {31'd0, dc_wr_req}, 32'd0);
    check("rep0_stall", {31'd0, wb_stall}, 32'd0);
    check("rep0_repeat", {31'd0, rep_repeat}, 32'd0);
    check("rep0_eip", {31'd0, eip_wr_en}, 32'd1);
    tick();
    check("rep0_eflags", eflags, 32'h0000_0043);
    check("rep0_retired", retired_cnt, 32'd5);

    // REP, COUNT=1: last iteration, 32-bit GPR write via size code 3
    @(negedge CLK);
    idle_inputs();
    WB_V = 1; WB_de_rep_wb = 1; WB_COUNT = 32'd1; WB_de_ld_gpr1_wb = 1;
    WB_ALU32_RESULT = 32'hDEAD_BEEF; WB_de_datasize_all = 2'd3;
    settle();
    check("rep1_ecx_en", {31'd0, ecx_wr_en}, 32'd1);
    check("rep1_ecx", ecx_wr_data, 32'd0);
    check("rep1_repeat", {31'd0, rep_repeat}, 32'd0);
    check("rep1_eip", {31'd0, eip_wr_en}, 32'd1);
    check("rep1_gpr_data", gpr_wr_data, 32'hDEAD_BEEF);
    tick();
    check("rep1_retired", retired_cnt, 32'd6);

    // All flags set through the full mask
    @(negedge CLK);
    idle_inputs();
    WB_V = 1; WB_de_flags_affected_wb = 7'h7F; WB_FLAGS = 32'hFFFF_FFFF;
    tick();
    check("allflags_eflags", eflags, 32'h0000_0CD7);
    check("allflags_retired", retired_cnt, 32'd7);

    // Reset during STORE_WAIT
    @(negedge CLK);
    idle_inputs();
    WB_V = 1; WB_de_dcache_write_wb = 1; WB_ADDRESS = 32'h0000_3000;
    tick();
    @(negedge CLK);
    settle();
    check("rstw_stall_before", {31'd0, wb_stall}, 32'd1);
    RST = 0;
    #1;
    check("rstw_req", {31'd0, dc_wr_req}, 32'd0);
    check("rstw_stall", {31'd0, wb_stall}, 32'd0);
    check("rstw_eflags", eflags, 32'h0000_0002);
    check("rstw_retired", retired_cnt, 32'd0);
    @(negedge CLK);
    idle_inputs();
    RST = 1;
    dc_wr_ack = 1;
    settle();
    check("rstw_post_req", {31'd0, dc_wr_req}, 32'd0);
    check("rstw_post_eip", {31'd0, eip_wr_en}, 32'd0);
    tick();
    tick();
    check("rstw_post_retired", retired_cnt, 32'd0);
    check("rstw_post_eflags", eflags, 32'h0000_0002);

    // Retired counter wrap
    @(negedge CLK);
    idle_inputs();
    force dut.retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt;
    WB_V = 1;
    tick();
    check("wrap_retired", retired_cnt, 32'd0);
    @(negedge CLK);
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
